// File: rtl/sobel_window_buffer_pkg.sv
// Shared defaults and pixel/window types for the Sobel 3x3 window generator.
package sobel_window_buffer_pkg;

  localparam int DEFAULT_PIXEL_WIDTH = 8;
  localparam int DEFAULT_IMG_WIDTH   = 8;
  localparam int DEFAULT_IMG_HEIGHT  = 8;

  typedef logic [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;

  // Element 0 sits at the LSBs: w0..w2 top row, w6..w8 bottom row.
  typedef pixel_t [8:0] window_t;

endpackage

// File: rtl/sobel_window_buffer_line_buffer.sv
// Enable-gated shift register holding one image line of pixel history.
module sobel_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  // Oldest entry: the pixel accepted DEPTH enables ago.
  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window.
module sobel_window_buffer
  import sobel_window_buffer_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int IMG_WIDTH   = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEFAULT_IMG_HEIGHT
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          clear_i,
  input  logic                          px_rdy_i,
  input  logic [PIXEL_WIDTH-1:0]        in_pixel_i,
  output logic [9*PIXEL_WIDTH-1:0]      window_o,
  output logic                          window_valid_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic                          frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic                          accept;
  logic [PIXEL_WIDTH-1:0]        lb0_out;
  logic [PIXEL_WIDTH-1:0]        lb1_out;
  logic [CW-1:0]                 col_p0;
  logic [RW-1:0]                 row_p0;
  logic                          interior_p0;
  logic                          last_p0;
  logic [8:0][PIXEL_WIDTH-1:0]   window_p1;
  logic                          vld_p1;
  logic                          done_p1;

  // A clear in the same cycle as a strobe drops the pixel.
  assign accept      = px_rdy_i & ~clear_i;
  assign interior_p0 = (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
  assign last_p0     = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb0 (
    .clk  (clk_i),
    .rst  (reset_i),
    .en   (accept),
    .din  (in_pixel_i),
    .dout (lb0_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb1 (
    .clk  (clk_i),
    .rst  (reset_i),
    .en   (accept),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Stage p0: raster position of the next pixel to be accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (px_rdy_i) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  // Stage p1: window registers and strobes, one cycle after the accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      window_p1 <= '0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      vld_p1  <= accept & interior_p0;
      done_p1 <= accept & last_p0;
      if (accept) begin
        window_p1[0] <= window_p1[1];
        window_p1[1] <= window_p1[2];
        window_p1[2] <= lb1_out;
        window_p1[3] <= window_p1[4];
        window_p1[4] <= window_p1[5];
        window_p1[5] <= lb0_out;
        window_p1[6] <= window_p1[7];
        window_p1[7] <= window_p1[8];
        window_p1[8] <= in_pixel_i;
      end
    end
  end

  assign window_o       = window_p1;
  assign window_valid_o = vld_p1;
  assign frame_done_o   = done_p1;
  assign col_o          = col_p0;
  assign row_o          = row_p0;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for sobel_window_buffer (8x8 instance plus a 3x3 instance).
module tb_sobel_window_buffer;
  import sobel_window_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, rdy;
  logic [7:0] pix;
  window_t    window;
  logic       wv, done;
  logic [2:0] col, row;

  logic       rdy3;
  logic [7:0] pix3;
  window_t    window3;
  logic       wv3, done3;
  logic [1:0] col3, row3;

  sobel_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .px_rdy_i(rdy), .in_pixel_i(pix),
    .window_o(window), .window_valid_o(wv), .col_o(col), .row_o(row), .frame_done_o(done)
  );

  sobel_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .clear_i(1'b0), .px_rdy_i(rdy3), .in_pixel_i(pix3),
    .window_o(window3), .window_valid_o(wv3), .col_o(col3), .row_o(row3), .frame_done_o(done3)
  );

  typedef struct {
    window_t w;
    logic    done;
  } exp_t;

  typedef struct {
    int      base;
    int      gap;
    window_t first;
    window_t last;
  } vec_t;

  int      checks = 0;
  int      errors = 0;
  exp_t    q[$];
  logic [7:0] img [8][8];
  int      mr = 0, mc = 0;
  int      vcount = 0, dcount = 0;
  bit      got_first = 0;
  window_t first_w, last_w, last_exp;
  bit      last_acc_valid = 0;
  vec_t    tbl [3];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic window_t mkwin(input int a, b, c, d, e, f, g, h, i);
    window_t w;
    w[0] = 8'(a); w[1] = 8'(b); w[2] = 8'(c);
    w[3] = 8'(d); w[4] = 8'(e); w[5] = 8'(f);
    w[6] = 8'(g); w[7] = 8'(h); w[8] = 8'(i);
    return w;
  endfunction

  function automatic window_t model_win();
    window_t w;
    for (int k = 0; k < 9; k++) w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
    return w;
  endfunction

  // Every valid window pops the oldest expectation; stray strobes are flagged.
  always @(negedge clk) begin
    if (wv) begin
      vcount++;
      if (q.size() == 0) begin
        chk("spurious_valid", {71'd0, wv}, 72'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("window", window, e.w);
        chk("done_with_window", {71'd0, done}, {71'd0, e.done});
        if (!got_first) first_w = window;
        got_first = 1;
        last_w = window;
      end
    end else if (done) begin
      chk("done_without_valid", {71'd0, done}, 72'd0);
    end
    if (done) dcount++;
  end

  task automatic reset_stats();
    vcount = 0; dcount = 0; got_first = 0;
  endtask

  task automatic drive(input int p, input bit clr);
    @(negedge clk);
    rdy = 1'b1; clear = clr; pix = 8'(p);
    if (clr) begin
      mr = 0; mc = 0; last_acc_valid = 0;
    end else begin
      img[mr][mc] = 8'(p);
      if (mr >= 2 && mc >= 2) begin
        exp_t e;
        e.w = model_win();
        e.done = (mr == 7 && mc == 7);
        q.push_back(e);
        last_exp = e.w;
        last_acc_valid = 1;
      end else begin
        last_acc_valid = 0;
      end
      if (mc == 7) begin
        mc = 0;
        mr = (mr == 7) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rdy = 1'b0; clear = 1'b0;
      if (last_acc_valid) chk("hold", window, last_exp);
    end
  endtask

  task automatic run_frame(input int base, input int gap);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        drive(base + 8 * r + c, 0);
        if (gap > 0) idle($urandom_range(0, gap));
      end
    idle(3);
  endtask

  task automatic frame_end_checks(input string tag);
    chk({tag, "_count"}, 72'(vcount), 72'd36);
    chk({tag, "_done_count"}, 72'(dcount), 72'd1);
    chk({tag, "_queue_empty"}, 72'(q.size()), 72'd0);
    chk({tag, "_row"}, {69'd0, row}, 72'd0);
    chk({tag, "_col"}, {69'd0, col}, 72'd0);
  endtask

  initial begin
    tbl[0] = '{0,   0, mkwin(0, 1, 2, 8, 9, 10, 16, 17, 18),
                       mkwin(45, 46, 47, 53, 54, 55, 61, 62, 63)};
    tbl[1] = '{100, 0, mkwin(100, 101, 102, 108, 109, 110, 116, 117, 118),
                       mkwin(145, 146, 147, 153, 154, 155, 161, 162, 163)};
    tbl[2] = '{0,   5, mkwin(0, 1, 2, 8, 9, 10, 16, 17, 18),
                       mkwin(45, 46, 47, 53, 54, 55, 61, 62, 63)};

    reset = 1'b1; clear = 1'b0; rdy = 1'b0; pix = '0; rdy3 = 1'b0; pix3 = '0;
    repeat (2) @(negedge clk);
    chk("reset_window", window, 72'd0);
    chk("reset_valid", {71'd0, wv}, 72'd0);
    chk("reset_done", {71'd0, done}, 72'd0);
    chk("reset_row", {69'd0, row}, 72'd0);
    chk("reset_col", {69'd0, col}, 72'd0);
    chk("reset3_window", window3, 72'd0);
    reset = 1'b0;

    for (int v = 0; v < 3; v++) begin
      reset_stats();
      run_frame(tbl[v].base, tbl[v].gap);
      chk($sformatf("vec%0d_first", v), first_w, tbl[v].first);
      chk($sformatf("vec%0d_last", v), last_w, tbl[v].last);
      frame_end_checks($sformatf("vec%0d", v));
    end

    // Clear coincident with a strobe after pixel 30, then a fresh frame.
    for (int i = 0; i <= 30; i++) drive(i, 0);
    drive(200, 1);
    idle(1);
    chk("clear_valid", {71'd0, wv}, 72'd0);
    chk("clear_done", {71'd0, done}, 72'd0);
    chk("clear_row", {69'd0, row}, 72'd0);
    chk("clear_col", {69'd0, col}, 72'd0);
    q.delete();
    reset_stats();
    for (int i = 0; i < 18; i++) drive(50 + i, 0);
    idle(1);
    chk("clear_no_early_valid", {71'd0, wv}, 72'd0);
    drive(68, 0);
    idle(1);
    chk("clear_first_valid", {71'd0, wv}, 72'd1);
    chk("clear_first_window", window, mkwin(50, 51, 52, 58, 59, 60, 66, 67, 68));
    for (int i = 19; i < 64; i++) drive(50 + i, 0);
    idle(3);
    frame_end_checks("clear_frame");

    // One-cycle reset mid-frame after pixel 40.
    reset_stats();
    for (int i = 0; i <= 40; i++) drive(i, 0);
    @(negedge clk);
    rdy = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mr = 0; mc = 0; last_acc_valid = 0; q.delete();
    chk("rst_window", window, 72'd0);
    chk("rst_valid", {71'd0, wv}, 72'd0);
    chk("rst_done", {71'd0, done}, 72'd0);
    chk("rst_row", {69'd0, row}, 72'd0);
    chk("rst_col", {69'd0, col}, 72'd0);
    reset_stats();
    run_frame(0, 0);
    chk("rst_frame_first", first_w, mkwin(0, 1, 2, 8, 9, 10, 16, 17, 18));
    frame_end_checks("rst_frame");

    // 3x3 instance: single window, valid and done together after pixel 9.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 9) chk("small_no_early_valid", {71'd0, wv3}, 72'd0);
      rdy3 = 1'b1; pix3 = 8'(i);
    end
    @(negedge clk);
    rdy3 = 1'b0;
    chk("small_valid", {71'd0, wv3}, 72'd1);
    chk("small_done", {71'd0, done3}, 72'd1);
    chk("small_window", window3, mkwin(1, 2, 3, 4, 5, 6, 7, 8, 9));
    chk("small_row", {70'd0, row3}, 72'd0);
    chk("small_col", {70'd0, col3}, 72'd0);
    @(negedge clk);
    chk("small_valid_drop", {71'd0, wv3}, 72'd0);
    chk("small_done_drop", {71'd0, done3}, 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
